// File: rtl/qp_mem_port_ctrl.sv
// qp_mem_port_ctrl
//   Memory-side port controller between the Wishbone slave controller and the
//   query-patch SRAM. The bus sees each PATCH_W-bit patch as two 32-bit halves
//   (lower = bits 31:0, upper = bits PATCH_W-1:32); this block turns those
//   half accesses into whole-patch SRAM reads and writes.
//   - Lower-half writes are staged; the upper-half write commits the patch.
//   - A one-entry read cache lets the second half of a patch be read without
//     another SRAM access.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   wb_mode           1 = bus owns the SRAM, 0 = engine owns it
//   req_stb/we/addr   request (addr[0] = half, addr[ADDR_W:1] = patch address)
//   req_wdata         write data
//   ack, rdata        one-cycle completion pulse and read data (registered)
//   mem_csb0/web0     SRAM chip select / write enable, active low (registered)
//   mem_addr0         SRAM patch address
//   mem_wpatch0       SRAM write patch
//   mem_rpatch0       SRAM read patch, valid the cycle after a read is issued
module qp_mem_port_ctrl #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int NUM_QUERYS = 408,
  parameter int ADDR_W     = $clog2(NUM_QUERYS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wb_mode,
  input  logic                                req_stb,
  input  logic                                req_we,
  input  logic [ADDR_W:0]                     req_addr,
  input  logic [31:0]                         req_wdata,
  output logic                                ack,
  output logic [31:0]                         rdata,
  output logic                                mem_csb0,
  output logic                                mem_web0,
  output logic [ADDR_W-1:0]                   mem_addr0,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0]    mem_wpatch0,
  input  logic [PATCH_SIZE*DATA_WIDTH-1:0]    mem_rpatch0
);

  localparam int PATCH_W = PATCH_SIZE*DATA_WIDTH;
  localparam int UPPER_W = PATCH_W - 32;
  localparam logic [ADDR_W:0] NQ = (ADDR_W+1)'(NUM_QUERYS);

  typedef enum logic [1:0] {IDLE, MEM, CAP, ACK} state_t;

  state_t              state, state_n;
  logic                ack_n, csb_n, web_n;
  logic [31:0]         rdata_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [PATCH_W-1:0]  wpatch_n;

  logic                stage_valid, stage_valid_n;
  logic [ADDR_W-1:0]   stage_addr, stage_addr_n;
  logic [31:0]         stage_data, stage_data_n;

  logic                cache_valid, cache_valid_n;
  logic [ADDR_W-1:0]   cache_addr, cache_addr_n;
  logic [PATCH_W-1:0]  cache_data, cache_data_n;

  // request fields held across MEM/CAP (req_stb may drop mid-transaction)
  logic                hold_we, hold_we_n;
  logic                hold_half, hold_half_n;
  logic [ADDR_W-1:0]   hold_paddr, hold_paddr_n;

  logic                req_half;
  logic [ADDR_W-1:0]   req_paddr;
  logic                req_oor, cache_hit, stage_hit;
  logic [PATCH_W-1:0]  wr_patch;
  logic                unused_wdata;

  assign req_half     = req_addr[0];
  assign req_paddr    = req_addr[ADDR_W:1];
  assign req_oor      = ({1'b0, req_paddr} >= NQ);
  assign cache_hit    = cache_valid && (cache_addr == req_paddr);
  assign stage_hit    = stage_valid && (stage_addr == req_paddr);
  // top bits of the upper-half write word have no home in the patch
  assign wr_patch     = {req_wdata[UPPER_W-1:0], stage_hit ? stage_data : 32'h0};
  assign unused_wdata = ^req_wdata[31:UPPER_W];

  function automatic logic [31:0] half_sel(input logic [PATCH_W-1:0] p, input logic h);
    return h ? {{(32-UPPER_W){1'b0}}, p[PATCH_W-1:32]} : p[31:0];
  endfunction

  always_comb begin
    state_n       = state;
    ack_n         = 1'b0;
    csb_n         = 1'b1;
    web_n         = 1'b1;
    rdata_n       = rdata;
    addr_n        = mem_addr0;
    wpatch_n      = mem_wpatch0;
    stage_valid_n = stage_valid;
    stage_addr_n  = stage_addr;
    stage_data_n  = stage_data;
    cache_valid_n = cache_valid;
    cache_addr_n  = cache_addr;
    cache_data_n  = cache_data;
    hold_we_n     = hold_we;
    hold_half_n   = hold_half;
    hold_paddr_n  = hold_paddr;

    case (state)
      IDLE: begin
        if (req_stb && !ack) begin
          hold_we_n    = req_we;
          hold_half_n  = req_half;
          hold_paddr_n = req_paddr;
          if (!wb_mode || req_oor) begin
            rdata_n = 32'h0;
            ack_n   = 1'b1;
            state_n = ACK;
          end else if (req_we && !req_half) begin
            stage_valid_n = 1'b1;
            stage_addr_n  = req_paddr;
            stage_data_n  = req_wdata;
            ack_n         = 1'b1;
            state_n       = ACK;
          end else if (req_we) begin
            addr_n        = req_paddr;
            wpatch_n      = wr_patch;
            csb_n         = 1'b0;
            web_n         = 1'b0;
            stage_valid_n = 1'b0;
            // keep the cached copy coherent with what is being committed
            if (cache_hit) cache_data_n = wr_patch;
            state_n       = MEM;
          end else if (cache_hit) begin
            rdata_n = half_sel(cache_data, req_half);
            ack_n   = 1'b1;
            state_n = ACK;
          end else begin
            addr_n  = req_paddr;
            csb_n   = 1'b0;
            state_n = MEM;
          end
        end
      end
      MEM: begin
        if (hold_we) begin
          ack_n   = 1'b1;
          state_n = ACK;
        end else begin
          state_n = CAP;
        end
      end
      CAP: begin
        cache_valid_n = 1'b1;
        cache_addr_n  = hold_paddr;
        cache_data_n  = mem_rpatch0;
        rdata_n       = half_sel(mem_rpatch0, hold_half);
        ack_n         = 1'b1;
        state_n       = ACK;
      end
      ACK: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // the engine may rewrite the SRAM while it owns it
    if (!wb_mode) begin
      stage_valid_n = 1'b0;
      cache_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ack         <= 1'b0;
      rdata       <= 32'h0;
      mem_csb0    <= 1'b1;
      mem_web0    <= 1'b1;
      mem_addr0   <= '0;
      mem_wpatch0 <= '0;
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_data  <= 32'h0;
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
      hold_we     <= 1'b0;
      hold_half   <= 1'b0;
      hold_paddr  <= '0;
    end else begin
      state       <= state_n;
      ack         <= ack_n;
      rdata       <= rdata_n;
      mem_csb0    <= csb_n;
      mem_web0    <= web_n;
      mem_addr0   <= addr_n;
      mem_wpatch0 <= wpatch_n;
      stage_valid <= stage_valid_n;
      stage_addr  <= stage_addr_n;
      stage_data  <= stage_data_n;
      cache_valid <= cache_valid_n;
      cache_addr  <= cache_addr_n;
      cache_data  <= cache_data_n;
      hold_we     <= hold_we_n;
      hold_half   <= hold_half_n;
      hold_paddr  <= hold_paddr_n;
    end
  end

endmodule

// File: tb/tb_qp_mem_port_ctrl.sv
// Bench for qp_mem_port_ctrl: directed requests, a transaction-level model
// (patch store + cache/staging bookkeeping) that predicts latency, SRAM
// access and read data, and a per-cycle compare process.
module tb_qp_mem_port_ctrl;
  localparam int NQ = 408;
  localparam logic [54:0] JUNK = 55'h2A_AAAA_5555_5555;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_mode = 1'b0;
  logic        req_stb = 1'b0;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        ack;
  logic [31:0] rdata;
  logic        mem_csb0, mem_web0;
  logic [8:0]  mem_addr0;
  logic [54:0] mem_wpatch0;
  logic [54:0] mem_rpatch0 = JUNK;

  qp_mem_port_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wb_mode(wb_mode), .req_stb(req_stb),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .mem_csb0(mem_csb0), .mem_web0(mem_web0),
    .mem_addr0(mem_addr0), .mem_wpatch0(mem_wpatch0), .mem_rpatch0(mem_rpatch0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: read data appears the cycle after the access, junk otherwise
  logic [54:0] sram [0:NQ-1];
  always @(posedge clk) begin
    if (!mem_csb0) begin
      if (!mem_web0) sram[mem_addr0] <= mem_wpatch0;
      else           mem_rpatch0 <= sram[mem_addr0];
    end else begin
      mem_rpatch0 <= JUNK;
    end
  end

  // model state
  logic [54:0] ref_mem [0:NQ-1];
  bit          m_sv = 0, m_cv = 0;
  int          m_sa = 0, m_ca = 0;
  logic [31:0] m_sd = '0;

  // current transaction expectations
  bit          tx_active = 0, tx_acc = 0, tx_wr = 0, tx_we = 0;
  int          tx_n = 0, tx_lat = 1;
  logic [8:0]  tx_addr = '0;
  logic [54:0] tx_wp = '0;
  logic [31:0] tx_rd = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // per-cycle compare: ack, strobes, address/patch on access, rdata on ack
  always @(negedge clk) begin : cmp
    int d;
    logic ea, ec, ew;
    if (rst_n) begin
      d  = tx_active ? (cyc - tx_n) : -1;
      ea = (d == tx_lat);
      ec = !(tx_acc && d == 1);
      ew = !(tx_wr && d == 1);
      chk("ack", 64'(ack), 64'(ea));
      chk("csb0", 64'(mem_csb0), 64'(ec));
      chk("web0", 64'(mem_web0), 64'(ew));
      if (!ec) chk("addr0", 64'(mem_addr0), 64'(tx_addr));
      if (!ew) chk("wpatch0", 64'(mem_wpatch0), 64'(tx_wp));
      if (ea && !tx_we) chk("rdata", 64'(rdata), 64'(tx_rd));
    end
  end

  task automatic do_req(input bit we, input bit half, input int paddr,
                        input logic [31:0] wd, input bit drop, output logic [31:0] got);
    logic [54:0] p;
    logic [31:0] lo;
    logic [8:0]  pa;
    bit          done;
    pa = paddr[8:0];
    tx_acc = 0; tx_wr = 0; tx_rd = '0; tx_lat = 1; tx_we = we;
    got = '0;
    if (!wb_mode || paddr >= NQ) begin
      tx_lat = 1;
    end else if (we && !half) begin
      m_sv = 1; m_sa = paddr; m_sd = wd;
    end else if (we) begin
      lo = (m_sv && m_sa == paddr) ? m_sd : 32'h0;
      tx_wp = {wd[22:0], lo};
      ref_mem[paddr] = tx_wp;
      m_sv = 0; tx_acc = 1; tx_wr = 1; tx_lat = 2; tx_addr = pa;
    end else begin
      if (!(m_cv && m_ca == paddr)) begin
        tx_lat = 3; tx_acc = 1; tx_addr = pa; m_cv = 1; m_ca = paddr;
      end
      p = ref_mem[paddr];
      tx_rd = half ? {9'h0, p[54:32]} : p[31:0];
    end
    @(negedge clk);
    req_we = we; req_addr = {pa, half}; req_wdata = wd; req_stb = 1'b1;
    tx_n = cyc; tx_active = 1;
    done = 0;
    for (int k = 1; k <= 20 && !done; k++) begin
      @(negedge clk);
      if (drop && k == 1) req_stb = 1'b0;
      if (ack) begin done = 1; got = rdata; end
    end
    if (!done) begin
      errors++;
      $display("FAIL ack_timeout: no ack within 20 cycles for addr %0d", paddr);
    end
    req_stb = 1'b0;
    @(negedge clk);
    tx_active = 0;
  endtask

  task automatic set_wb(input bit v);
    @(negedge clk);
    wb_mode = v;
    if (!v) begin m_sv = 0; m_cv = 0; end
  endtask

  logic [31:0] g;

  initial begin
    for (int i = 0; i < NQ; i++) begin
      sram[i]    = {23'(i), 32'(i * 3 + 7)};
      ref_mem[i] = {23'(i), 32'(i * 3 + 7)};
    end
    sram[1]    = 55'h00_1010_DEAD_BEEF;
    ref_mem[1] = 55'h00_1010_DEAD_BEEF;

    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_csb0", 64'(mem_csb0), 64'd1);
    chk("rst_web0", 64'(mem_web0), 64'd1);
    chk("rst_addr0", 64'(mem_addr0), 64'd0);
    chk("rst_wpatch0", 64'(mem_wpatch0), 64'd0);
    rst_n = 1'b1;
    set_wb(1);

    // staged lower + committed upper
    do_req(1, 0, 2, 32'h01234567, 0, g);
    do_req(1, 1, 2, 32'h000BCDEF, 0, g);
    chk("wr2_patch", 64'(sram[2]), 64'(55'h0B_CDEF_0123_4567));

    // miss then hit on the same patch
    do_req(0, 0, 1, 32'h0, 0, g);
    chk("rd1_lo", 64'(g), 64'h0000_0000_DEAD_BEEF);
    do_req(0, 1, 1, 32'h0, 0, g);
    chk("rd1_hi", 64'(g), 64'h0000_0000_0000_1010);

    // upper write with nothing staged, high word bits truncated
    do_req(1, 1, 5, 32'hFFFFFFFF, 0, g);
    chk("wr5_patch", 64'(sram[5]), 64'(55'h7F_FFFF_0000_0000));

    // out of range
    do_req(0, 0, 408, 32'h0, 0, g);
    chk("oor_rd", 64'(g), 64'd0);
    do_req(1, 0, 511, 32'h55555555, 0, g);
    do_req(0, 1, 511, 32'h0, 0, g);

    // stb dropped mid-transaction on a miss
    do_req(0, 1, 2, 32'h0, 1, g);
    chk("rd2_hi", 64'(g), 64'h0000_0000_000B_CDEF);

    // cache kept coherent by an upper write to the cached patch
    do_req(0, 0, 3, 32'h0, 0, g);
    do_req(1, 0, 3, 32'hAAAA5555, 0, g);
    do_req(1, 1, 3, 32'h00012345, 0, g);
    do_req(0, 1, 3, 32'h0, 0, g);
    chk("rd3_hi", 64'(g), 64'h0000_0000_0001_2345);
    do_req(0, 0, 3, 32'h0, 0, g);
    chk("rd3_lo", 64'(g), 64'h0000_0000_AAAA_5555);

    // staged address mismatch gives a zero lower half
    do_req(1, 0, 6, 32'h11111111, 0, g);
    do_req(1, 1, 7, 32'h00000001, 0, g);
    chk("wr7_patch", 64'(sram[7]), 64'(55'h00_0001_0000_0000));

    // engine ownership drops staging and cache
    do_req(1, 0, 8, 32'hCAFEF00D, 0, g);
    set_wb(0);
    do_req(0, 0, 1, 32'h0, 0, g);
    chk("wb0_rd", 64'(g), 64'd0);
    do_req(1, 1, 4, 32'h7, 0, g);
    set_wb(1);
    do_req(0, 1, 1, 32'h0, 0, g);
    chk("wb1_rd1_hi", 64'(g), 64'h0000_0000_0000_1010);
    do_req(1, 1, 8, 32'h3, 0, g);

    // reset during MEM of a read miss
    tx_acc = 1; tx_wr = 0; tx_we = 0; tx_lat = 3; tx_addr = 9'd9;
    @(negedge clk);
    req_we = 1'b0; req_addr = {9'd9, 1'b0}; req_stb = 1'b1;
    tx_n = cyc; tx_active = 1;
    @(negedge clk);
    #2;
    rst_n = 1'b0; tx_active = 0; req_stb = 1'b0;
    m_sv = 0; m_cv = 0;
    #1;
    chk("rstmid_csb0", 64'(mem_csb0), 64'd1);
    chk("rstmid_ack", 64'(ack), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rstmid_noack", 64'(ack), 64'd0);
    end
    rst_n = 1'b1;
    do_req(0, 0, 1, 32'h0, 0, g);
    chk("post_rst_rd1", 64'(g), 64'h0000_0000_DEAD_BEEF);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qp_mem_port_ctrl.md
Name: qp_mem_port_ctrl

Overview:
- Memory-side port controller between the Wishbone slave controller and the query-patch SRAM.
- Translates 32-bit half-word bus accesses (lower/upper) into full 55-bit patch reads and writes (PATCH_SIZE x DATA_WIDTH).
- Lower-half writes are held in a staging register; upper-half writes commit the full patch.
- Holds a one-entry read cache so that reading the upper half after the lower half does not issue a second SRAM read.

Parameters:
- DATA_WIDTH, 11, bits per patch element.
- PATCH_SIZE, 5, elements per patch; PATCH_W = PATCH_SIZE*DATA_WIDTH = 55.
- NUM_QUERYS, 408, number of patch entries in the SRAM.
- ADDR_W, $clog2(NUM_QUERYS) = 9, patch address width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- wb_mode  in  1  1 = bus owns the SRAM; 0 = engine owns it.
- req_stb  in  1  request valid; held until ack.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W+1  [0] selects half (0 = lower bits 31:0, 1 = upper bits 54:32); [ADDR_W:1] is the patch address.
- req_wdata  in  32  write data.
- ack  out  1  one-cycle completion pulse.
- rdata  out  32  read data, valid when ack=1.
- mem_csb0  out  1  SRAM chip select, active low.
- mem_web0  out  1  SRAM write enable, active low.
- mem_addr0  out  ADDR_W  SRAM address.
- mem_wpatch0  out  PATCH_W  SRAM write data.
- mem_rpatch0  in  PATCH_W  SRAM read data, valid the cycle after a read is issued.

Behaviour:
- Reset (async, rst_n=0):
  - ack=0, rdata=0, mem_csb0=1, mem_web0=1, mem_addr0=0, mem_wpatch0=0.
  - State IDLE; staging valid flag and cache valid flag cleared; staging and cache data = 0.
- All outputs are registered.
- States:
  - IDLE: accepts req_stb=1 when ack=0. A request is never accepted in the same cycle ack is high.
  - MEM: SRAM access is driven this cycle.
  - CAP: mem_rpatch0 is captured into the cache.
  - ACK: ack=1 for exactly one cycle, then return to IDLE.
- Write lower (we=1, half=0):
  - stage_data <= req_wdata; stage_addr <= patch address; stage_valid <= 1.
  - No SRAM access. IDLE -> ACK; ack at accept+1.
- Write upper (we=1, half=1):
  - mem_wpatch0 = {req_wdata[22:0], lower}, where lower = stage_data if stage_valid and stage_addr matches, else 32'h0.
  - req_wdata[31:23] are ignored.
  - IDLE -> MEM with csb0=0, web0=0 at accept+1 -> ACK; ack at accept+2.
  - stage_valid cleared.
  - If the cache is valid at the same address, the cache is updated with the written word.
- Read, cache hit (cache_valid and address match):
  - IDLE -> ACK; ack at accept+1.
  - rdata = cache[31:0] for the lower half; {9'b0, cache[54:32]} for the upper half.
- Read, cache miss:
  - IDLE -> MEM with csb0=0, web0=1 at accept+1.
  - -> CAP at accept+2: capture mem_rpatch0; cache_valid <= 1.
  - -> ACK at accept+3 with rdata selected as for a hit.
- Out-of-range address (patch address >= NUM_QUERYS):
  - Acked at accept+1; rdata=0; no SRAM access; staging and cache unchanged.
- wb_mode=0:
  - Every request is acked at accept+1 with rdata=0 and no SRAM access.
  - Cache and staging valid flags are cleared every cycle while wb_mode=0, because the engine may rewrite the SRAM.
- mem_csb0/mem_web0 return to 1 in every state other than MEM.
- req_stb dropping mid-transaction: the transaction completes anyway and ack is still pulsed.
- Reset mid-transaction: state returns to IDLE immediately; no ack; the SRAM strobe is deasserted asynchronously.

Test Plan:
- Reset, then wb_mode=1; write lower addr 2 = 0x01234567; write upper addr 2 = 0x000BCDEF -> first ack at accept+1 with no SRAM access; then csb0=0, web0=0, addr0=2, wpatch0=55'h0B_CDEF_0123_4567, ack at accept+2.
- Read lower addr 1 with the SRAM returning 55'h00_1010_DEAD_BEEF -> csb0=0, web0=1 for exactly one cycle, ack at accept+3, rdata=0xDEADBEEF. Then read upper addr 1 -> no SRAM access, ack at accept+1, rdata=0x00001010.
- Write upper addr 5 = 0xFFFFFFFF with no lower staged -> wpatch0=55'h7F_FFFF_0000_0000 (upper bits truncated, lower half zero).
- Read patch address 408 -> ack at accept+1, rdata=0, csb0 stays 1 throughout.
- wb_mode=0: read addr 1 -> ack, rdata=0, no SRAM access. Return wb_mode to 1 and read upper addr 1 -> cache miss, SRAM read issued.
- Assert rst_n=0 during the MEM state of a read -> ack never pulses, csb0=1 immediately. After release, a new read completes normally.
